// File: rtl/predictor_pkg.sv
// Shared types and constants for the branch predictor stimulus path.
//   trace_state_t : run-control states of branch_trace_gen
//   trace_entry_t : one trace entry, {index, outcome}, at the default index width
//   DEFAULT_K     : default predictor index width
package predictor_pkg;

   localparam int unsigned DEFAULT_K = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } trace_state_t;

   // Memory words use this same bit layout: index in the upper bits, outcome in bit 0.
   typedef struct packed {
      logic [DEFAULT_K-1:0] index;
      logic                 outcome;
   } trace_entry_t;

endpackage

// File: rtl/trace_mem.sv
// Trace register file: DEPTH entries of {index, outcome}.
// Synchronous write, combinational read, asynchronous active-low clear.
// Ports:
//   clk, reset     : clock, async active-low clear of every entry
//   we/waddr/wdata : write strobe, address and entry
//   raddr/rdata    : combinational read port
module trace_mem #(
   parameter  int unsigned K     = 4,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [K:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [K:0]    rdata
);

   logic [K:0] mem [DEPTH];

   // Storage with whole-array clear on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/branch_trace_gen.sv
// Replays a programmed trace of (index, outcome) pairs to the predictor over a
// valid/ready handshake and accumulates saturating hit/miss/issued statistics.
// Ports:
//   clk, reset                         : clock, async active-low reset
//   wr_en/wr_addr/wr_index/wr_outcome  : trace programming (ignored while busy)
//   start, trace_len, loops            : run request and its pass geometry
//   br_valid/br_ready/index/branch_outcome/prediction : predictor handshake
//   busy, done                         : run status
//   hit_count/miss_count/issued_count  : run statistics
module branch_trace_gen
   import predictor_pkg::*;
#(
   parameter  int unsigned K     = DEFAULT_K,
   parameter  int unsigned DEPTH = 16,
   parameter  int unsigned CW    = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [K-1:0]  wr_index,
   input  logic          wr_outcome,
   input  logic          start,
   input  logic [AW:0]   trace_len,
   input  logic [7:0]    loops,
   output logic          br_valid,
   input  logic          br_ready,
   output logic [K-1:0]  index,
   output logic          branch_outcome,
   input  logic          prediction,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] hit_count,
   output logic [CW-1:0] miss_count,
   output logic [CW-1:0] issued_count
);

   trace_state_t  state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [7:0]    loop_q, loop_d;
   logic [AW:0]   len_q, len_d;
   logic [7:0]    loops_q, loops_d;
   logic [CW-1:0] hit_d, miss_d, iss_d;
   logic [K:0]    rd_entry;
   logic          mem_we;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + CW'(1);
   endfunction

   // Trace can only be reprogrammed outside a run.
   assign mem_we = wr_en && (state_q != ISSUE);

   trace_mem #(
      .K     (K),
      .DEPTH (DEPTH)
   ) u_trace_mem (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .waddr (wr_addr),
      .wdata ({wr_index, wr_outcome}),
      .raddr (ptr_q),
      .rdata (rd_entry)
   );

   assign index          = rd_entry[K:1];
   assign branch_outcome = rd_entry[0];

   // Next-state, pointer and statistics update.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      loop_d  = loop_q;
      len_d   = len_q;
      loops_d = loops_q;
      hit_d   = hit_count;
      miss_d  = miss_count;
      iss_d   = issued_count;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               len_d   = (trace_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : trace_len;
               loops_d = loops;
               ptr_d   = '0;
               loop_d  = '0;
               hit_d   = '0;
               miss_d  = '0;
               iss_d   = '0;
               state_d = ((len_d == '0) || (loops == 8'd0)) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (br_ready) begin
               iss_d = sat_inc(issued_count);
               if (prediction == branch_outcome) begin
                  hit_d = sat_inc(hit_count);
               end else begin
                  miss_d = sat_inc(miss_count);
               end
               if ((AW+1)'(ptr_q) == len_q - (AW+1)'(1)) begin
                  ptr_d = '0;
                  if (loop_q == loops_q - 8'd1) begin
                     state_d = DONE;
                  end else begin
                     loop_d = loop_q + 8'd1;
                  end
               end else begin
                  ptr_d = ptr_q + AW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, run context and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         loop_q       <= '0;
         len_q        <= '0;
         loops_q      <= '0;
         br_valid     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         hit_count    <= '0;
         miss_count   <= '0;
         issued_count <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         loop_q       <= loop_d;
         len_q        <= len_d;
         loops_q      <= loops_d;
         br_valid     <= (state_d == ISSUE);
         busy         <= (state_d == ISSUE);
         done         <= (state_d == DONE);
         hit_count    <= hit_d;
         miss_count   <= miss_d;
         issued_count <= iss_d;
      end
   end

endmodule

// File: tb/tb_branch_trace_gen.sv
// Bench for branch_trace_gen: a default instance (CW=16) and a narrow-counter
// instance (CW=4) share all stimulus; a transaction-level model predicts both.
module tb_branch_trace_gen;

   localparam int K     = 4;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [K-1:0]  wr_index;
   logic          wr_outcome;
   logic          start;
   logic [AW:0]   trace_len;
   logic [7:0]    loops;
   logic          br_ready;
   logic          prediction;

   logic          br_valid, busy, done, branch_outcome;
   logic [K-1:0]  index;
   logic [15:0]   hit_count, miss_count, issued_count;
   logic          br_valid4, busy4, done4, branch_outcome4;
   logic [K-1:0]  index4;
   logic [3:0]    hit_count4, miss_count4, issued_count4;

   always #5 clk = ~clk;

   branch_trace_gen #(.K(K), .DEPTH(DEPTH), .CW(16)) u_dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_index(wr_index),
      .wr_outcome(wr_outcome), .start(start), .trace_len(trace_len), .loops(loops),
      .br_valid(br_valid), .br_ready(br_ready), .index(index), .branch_outcome(branch_outcome),
      .prediction(prediction), .busy(busy), .done(done), .hit_count(hit_count),
      .miss_count(miss_count), .issued_count(issued_count)
   );

   branch_trace_gen #(.K(K), .DEPTH(DEPTH), .CW(4)) u_dut4 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_index(wr_index),
      .wr_outcome(wr_outcome), .start(start), .trace_len(trace_len), .loops(loops),
      .br_valid(br_valid4), .br_ready(br_ready), .index(index4), .branch_outcome(branch_outcome4),
      .prediction(prediction), .busy(busy4), .done(done4), .hit_count(hit_count4),
      .miss_count(miss_count4), .issued_count(issued_count4)
   );

   int n_vec  = 0;
   int n_fail = 0;

   // Model: trace contents, queue of branches still owed in this run, raw counts.
   logic [K:0]   mem_m [DEPTH];
   logic [K:0]   exp_q [$];
   bit           m_run, m_done;
   int           m_hit, m_miss, m_iss;
   logic [K-1:0] acc_q [$];
   int           valid_cycles = 0;

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   // Compare both instances against the model mid-cycle, then advance the model
   // over the coming rising edge using the inputs that edge will sample.
   always @(negedge clk) begin
      if (!reset) begin
         foreach (mem_m[i]) mem_m[i] = '0;
         exp_q.delete();
         m_run = 1'b0; m_done = 1'b0;
         m_hit = 0; m_miss = 0; m_iss = 0;
         check("rst_valid", {31'd0, br_valid}, 0);
         check("rst_busy", {31'd0, busy}, 0);
         check("rst_done", {31'd0, done}, 0);
         check("rst_index", {28'd0, index}, 0);
         check("rst_outcome", {31'd0, branch_outcome}, 0);
         check("rst_counts", {hit_count, miss_count | issued_count}, 0);
         check("rst_counts4", {20'd0, hit_count4, miss_count4, issued_count4}, 0);
      end else begin
         logic [K:0] e;
         int         len;
         e = m_run ? exp_q[0] : mem_m[0];
         check("br_valid", {31'd0, br_valid}, {31'd0, m_run});
         check("busy", {31'd0, busy}, {31'd0, m_run});
         check("done", {31'd0, done}, {31'd0, m_done});
         check("index", {28'd0, index}, {28'd0, e[K:1]});
         check("outcome", {31'd0, branch_outcome}, {31'd0, e[0]});
         check("hit_count", {16'd0, hit_count}, sat(m_hit, 16));
         check("miss_count", {16'd0, miss_count}, sat(m_miss, 16));
         check("issued_count", {16'd0, issued_count}, sat(m_iss, 16));
         check("br_valid4", {31'd0, br_valid4}, {31'd0, m_run});
         check("done4", {31'd0, done4}, {31'd0, m_done});
         check("index4", {27'd0, index4, branch_outcome4}, {27'd0, e});
         check("hit_count4", {28'd0, hit_count4}, sat(m_hit, 4));
         check("miss_count4", {28'd0, miss_count4}, sat(m_miss, 4));
         check("issued_count4", {28'd0, issued_count4}, sat(m_iss, 4));
         if (br_valid) valid_cycles++;

         if (m_run) begin
            if (br_ready) begin
               acc_q.push_back(index);
               m_iss++;
               if (prediction == exp_q[0][0]) m_hit++;
               else m_miss++;
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  m_run  = 1'b0;
                  m_done = 1'b1;
               end
            end
         end else begin
            if (wr_en) mem_m[wr_addr] = {wr_index, wr_outcome};
            if (start) begin
               len = (int'(trace_len) > DEPTH) ? DEPTH : int'(trace_len);
               exp_q.delete();
               for (int l = 0; l < int'(loops); l++)
                  for (int p = 0; p < len; p++)
                     exp_q.push_back(mem_m[p]);
               m_hit = 0; m_miss = 0; m_iss = 0;
               m_run  = (exp_q.size() != 0);
               m_done = !m_run;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int idx, input int o);
      wr_en      = 1'b1;
      wr_addr    = AW'(a);
      wr_index   = K'(idx);
      wr_outcome = o[0];
      step();
      wr_en = 1'b0;
   endtask

   task automatic write_basic();
      int oc [4];
      oc = '{1, 1, 0, 1};
      for (int i = 0; i < 4; i++) wr(i, i, oc[i]);
   endtask

   // rmode: 0 ready=1, 1 ready alternating from 0, 2 random ready + noise,
   //        3 ready=1 + noise (writes/starts during the run).
   // pmode: 0 prediction=1, 1 prediction=0, 2 random.
   task automatic do_run(input int len, input int lps, input int rmode, input int pmode,
                         output int vcyc, output int acc0);
      int v0;
      acc0      = acc_q.size();
      v0        = valid_cycles;
      trace_len = (AW+1)'(len);
      loops     = 8'(lps);
      start     = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (done) break;
         case (rmode)
            0, 3:    br_ready = 1'b1;
            1:       br_ready = i[0];
            default: br_ready = 1'($urandom_range(0, 1));
         endcase
         case (pmode)
            0:       prediction = 1'b1;
            1:       prediction = 1'b0;
            default: prediction = 1'($urandom_range(0, 1));
         endcase
         if (rmode >= 2) begin
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_addr    = AW'($urandom_range(0, DEPTH - 1));
            wr_index   = K'($urandom);
            wr_outcome = 1'($urandom);
            start      = ($urandom_range(0, 7) == 0);
         end
         step();
      end
      start = 1'b0;
      wr_en = 1'b0;
      if (!done) check("run_timeout", 0, 1);
      vcyc = valid_cycles - v0;
   endtask

   task automatic check_basic_result(input string tag, input int acc0);
      check({tag, "_hit"}, {16'd0, hit_count}, 6);
      check({tag, "_miss"}, {16'd0, miss_count}, 2);
      check({tag, "_issued"}, {16'd0, issued_count}, 8);
      check({tag, "_model_hit"}, m_hit, 6);
      check({tag, "_done"}, {31'd0, done}, 1);
      check({tag, "_seq_len"}, acc_q.size() - acc0, 8);
      for (int i = 0; i < 8; i++)
         if (acc0 + i < acc_q.size())
            check({tag, "_seq"}, {28'd0, acc_q[acc0 + i]}, i % 4);
   endtask

   initial begin
      int vc, a0;
      reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_index = '0; wr_outcome = 1'b0;
      start = 1'b0; trace_len = '0; loops = '0; br_ready = 1'b0; prediction = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();

      // Basic run.
      write_basic();
      do_run(4, 2, 0, 0, vc, a0);
      check_basic_result("basic", a0);
      check("basic_valid_cycles", vc, 8);
      step();
      check("done_held", {31'd0, done}, 1);

      // Backpressure.
      do_run(4, 2, 1, 0, vc, a0);
      check_basic_result("bp", a0);
      check("bp_valid_cycles", vc, 16);

      // Empty runs.
      do_run(0, 2, 0, 0, vc, a0);
      check("empty_len_valid", vc, 0);
      check("empty_len_issued", {16'd0, issued_count}, 0);
      check("empty_len_done", {31'd0, done}, 1);
      do_run(4, 0, 0, 0, vc, a0);
      check("empty_loops_valid", vc, 0);
      check("empty_loops_hit", {16'd0, hit_count}, 0);

      // Saturation on the narrow instance.
      for (int i = 0; i < 16; i++) wr(i, i, 1);
      do_run(16, 2, 0, 1, vc, a0);
      check("sat_miss4", {28'd0, miss_count4}, 15);
      check("sat_issued4", {28'd0, issued_count4}, 15);
      check("sat_hit4", {28'd0, hit_count4}, 0);
      check("sat_miss16", {16'd0, miss_count}, 32);
      check("sat_issued16", {16'd0, issued_count}, 32);

      // trace_len above DEPTH is clamped.
      do_run(20, 1, 0, 0, vc, a0);
      check("clamp_valid", vc, 16);
      check("clamp_hit", {16'd0, hit_count}, 16);

      // Abort after the third handshake, then restart.
      write_basic();
      trace_len = 5'd4; loops = 8'd2; br_ready = 1'b1; prediction = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      check("pre_abort_issued", {16'd0, issued_count}, 3);
      #2 reset = 1'b0;
      #1;
      check("abort_valid", {31'd0, br_valid}, 0);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_issued", {16'd0, issued_count}, 0);
      check("abort_index", {28'd0, index, 3'd0} >> 3, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      step();
      do_run(16, 1, 2, 2, vc, a0);
      for (int i = 0; i < 16; i++)
         if (a0 + i < acc_q.size()) check("cleared_mem_index", {28'd0, acc_q[a0 + i]}, 0);
      write_basic();
      do_run(4, 2, 3, 0, vc, a0);
      check_basic_result("restart", a0);

      // Randomised runs.
      for (int r = 0; r < 40; r++) begin
         int nw;
         nw = $urandom_range(0, 6);
         for (int w = 0; w < nw; w++)
            wr($urandom_range(0, DEPTH - 1), $urandom_range(0, 15), $urandom_range(0, 1));
         do_run($urandom_range(0, 31), $urandom_range(0, 3), 2, 2, vc, a0);
      end

      step();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
